sad_pred_sched: RTL
===================

Name: sad_pred_sched

Overview:
- Sequences the shared combinational SAD datapath across PREDICTOR_N candidate predictions for one measurement block.
- Drives the candidate-select index to the external y_2 mux and samples the resulting SAD.
- Tracks the minimum SAD and returns the winning predictor index and its SAD through a valid/ready output handshake.
- Sits between the measurement predictor bank and the mode-decision/entropy stage.

Parameters:
- BLK_N, 4, block edge in pixels
- PIX_N, BLK_N*BLK_N, pixels per block
- PIX_WID, 8, pixel bit width
- MEA_WID, $clog2(PIX_N)+PIX_WID, measurement magnitude width (12 at defaults)
- SAD_WID, MEA_WID+$clog2(PIX_N)+1, SAD result width (17 at defaults)
- PREDICTOR_N, 2, number of candidate predictors; legal range 2..16
- IDX_WID, $clog2(PREDICTOR_N), candidate index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request a decision for the current block; accepted only when ready_o=1
- ready_o  out  1  high in IDLE
- pred_idx_o  out  IDX_WID  candidate select to the y_2 mux
- cand_vld_i  in  1  sad_i is valid for the current pred_idx_o this cycle
- sad_i  in  SAD_WID  unsigned SAD from the SAD datapath
- best_vld_o  out  1  result valid
- best_rdy_i  in  1  downstream accepts result
- best_idx_o  out  IDX_WID  index of minimum-SAD predictor
- best_sad_o  out  SAD_WID  minimum SAD value

Behaviour:
- Reset: state=IDLE, ready_o=1, pred_idx_o=0, best_vld_o=0, best_idx_o=0, best_sad_o=0; internal min register = all-ones.
- Reset asserted mid-evaluation or while holding a result aborts immediately to the reset state; a pending result is lost.
- FSM: IDLE -> EVAL -> OUT -> IDLE.
- IDLE:
  - ready_o=1.
  - On start_i: pred_idx_o<=0, min<=all-ones, go to EVAL.
  - start_i outside IDLE is ignored; it is not queued.
- EVAL:
  - ready_o=0.
  - Each cycle with cand_vld_i=1: sample sad_i for pred_idx_o.
  - Update when sad_i < min (strict less-than): min<=sad_i, best_idx<=pred_idx_o.
  - Ties therefore keep the lowest index.
  - If pred_idx_o==PREDICTOR_N-1, go to OUT; otherwise pred_idx_o increments.
  - With cand_vld_i=0, hold pred_idx_o and min (stall), with no cycle limit.
- Latency: with cand_vld_i held high, start_i accepted at cycle 0 gives best_vld_o=1 at cycle PREDICTOR_N+1 (the EVAL cycles occupy 1..PREDICTOR_N).
- OUT:
  - best_vld_o=1; best_idx_o and best_sad_o are registered and stable until the handshake.
  - When best_vld_o&&best_rdy_i: best_vld_o<=0, pred_idx_o<=0, go to IDLE.
  - ready_o returns the cycle after the handshake.
  - start_i in the handshake cycle is ignored.
- best_idx_o and best_sad_o retain the last result after the handshake.
- Arithmetic: unsigned compare on the full SAD_WID bits. sad_i = all-ones is never selected unless it is strictly below min; a first candidate of all-ones keeps best_idx=0 because best_idx is cleared at start.
- pred_idx_o never exceeds PREDICTOR_N-1 (no wrap when PREDICTOR_N is not a power of two).

Optional Feature:
- Macro SAD_EARLY_TERM_EN.
- Defined:
  - Adds input early_thr_i (SAD_WID).
  - In EVAL, a sampled sad_i <= early_thr_i updates best (if strictly below min) and goes directly to OUT; remaining candidates are skipped.
  - Adds output early_o (1): registered, set with best_vld_o when termination was early, cleared on the handshake.
- Undefined: port and logic absent; all PREDICTOR_N candidates are always evaluated.

Test Plan:
- Basic selection: PREDICTOR_N=4, cand_vld_i=1, SADs {40,25,60,30} -> best_vld_o at cycle 5, best_idx_o=1, best_sad_o=25.
- Tie and all-ones: SADs {25,25,90,25} -> best_idx_o=0; then SADs {all-ones x4} -> best_idx_o=0, best_sad_o=all-ones.
- Stall and backpressure:
  - cand_vld_i low for 3 cycles after idx 1 -> pred_idx_o holds at 1 and the result is unchanged.
  - best_rdy_i low for 5 cycles -> outputs stable, start_i ignored, ready_o=0 until the cycle after rdy.
- Reset mid-EVAL: rst_n low at pred_idx_o=2 -> all outputs at reset values asynchronously; next start_i gives a clean, correct result.
- Non-power-of-two: PREDICTOR_N=3, SADs {9,8,7} -> pred_idx_o sequence 0,1,2 then OUT, best_idx_o=2, never 3.
- Early termination (SAD_EARLY_TERM_EN): early_thr_i=10, PREDICTOR_N=4, SADs {50,8,...} -> OUT after idx 1, best_idx_o=1, best_sad_o=8, early_o=1; with the macro undefined, all 4 are evaluated.

Source files
------------

// File: rtl/sad_pred_sched.sv
// sad_pred_sched: steps the shared SAD datapath across PREDICTOR_N candidate
// predictions for one block, keeps the running minimum and returns the
// winning index and SAD through a valid/ready handshake.
// Optional early termination is compiled in with `define SAD_EARLY_TERM_EN.
module sad_pred_sched #(
    parameter int BLK_N       = 4,
    parameter int PIX_N       = BLK_N * BLK_N,
    parameter int PIX_WID     = 8,
    parameter int MEA_WID     = $clog2(PIX_N) + PIX_WID,
    parameter int SAD_WID     = MEA_WID + $clog2(PIX_N) + 1,
    parameter int PREDICTOR_N = 2,
    parameter int IDX_WID     = $clog2(PREDICTOR_N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               ready_o,
    output logic [IDX_WID-1:0] pred_idx_o,
    input  logic               cand_vld_i,
    input  logic [SAD_WID-1:0] sad_i,
    output logic               best_vld_o,
    input  logic               best_rdy_i,
    output logic [IDX_WID-1:0] best_idx_o,
    output logic [SAD_WID-1:0] best_sad_o
`ifdef SAD_EARLY_TERM_EN
  , input  logic [SAD_WID-1:0] early_thr_i
  , output logic               early_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(PREDICTOR_N - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [IDX_WID-1:0]   r_pred_idx;
    logic [IDX_WID-1:0]   r_cand_idx;   // running best index inside EVAL
    logic [SAD_WID-1:0]   r_min;        // running minimum inside EVAL
    logic [IDX_WID-1:0]   r_best_idx;   // published result, held across blocks
    logic [SAD_WID-1:0]   r_best_sad;
    logic                 w_better;
    logic                 w_last;
    logic                 w_early_hit;
    logic                 w_eval_done;

    assign w_better = cand_vld_i && (sad_i < r_min);
    assign w_last   = (r_pred_idx == LAST_IDX);

`ifdef SAD_EARLY_TERM_EN
    logic r_early;
    assign w_early_hit = cand_vld_i && (sad_i <= early_thr_i);
    assign early_o     = r_early;
`else
    assign w_early_hit = 1'b0;
`endif

    // The evaluation ends on the sampled candidate that is either the last one or below threshold.
    assign w_eval_done = cand_vld_i && (w_last || w_early_hit);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_i)     w_next_state = S_EVAL;
            S_EVAL:  if (w_eval_done) w_next_state = S_OUT;
            S_OUT:   if (best_rdy_i)  w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // Candidate index, running minimum and published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_idx <= '0;
            r_cand_idx <= '0;
            r_min      <= '1;
            r_best_idx <= '0;
            r_best_sad <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_pred_idx <= '0;
                        r_cand_idx <= '0;
                        r_min      <= '1;
                    end
                end
                S_EVAL: begin
                    if (w_better) begin
                        r_min      <= sad_i;
                        r_cand_idx <= r_pred_idx;
                    end
                    if (w_eval_done) begin
                        // Publish including the candidate sampled this very cycle.
                        r_best_idx <= w_better ? r_pred_idx : r_cand_idx;
                        r_best_sad <= w_better ? sad_i : r_min;
                    end else if (cand_vld_i) begin
                        r_pred_idx <= r_pred_idx + IDX_WID'(1);
                    end
                end
                S_OUT: begin
                    if (best_rdy_i) begin
                        r_pred_idx <= '0;
                    end
                end
                default: r_pred_idx <= '0;
            endcase
        end
    end

`ifdef SAD_EARLY_TERM_EN
    // Early flag: raised with the result when candidates were skipped, dropped on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_early <= 1'b0;
        end else if (r_state == S_EVAL && w_eval_done) begin
            r_early <= w_early_hit && !w_last;
        end else if (r_state == S_OUT && best_rdy_i) begin
            r_early <= 1'b0;
        end
    end
`endif

    assign ready_o    = (r_state == S_IDLE);
    assign best_vld_o = (r_state == S_OUT);
    assign pred_idx_o = r_pred_idx;
    assign best_idx_o = r_best_idx;
    assign best_sad_o = r_best_sad;

endmodule
